frame_slot_arbiter: RTL

- Shares the framer's single-bit data slot between NCH word-wide channel FIFOs.
- Selects channels round-robin, one word at a time, and serialises each word MSB-first.
- Presents the framer with a FIFO-like bit interface: o_emp, o_dat and an i_rack acknowledge.
- A frame-sync pulse from the framer realigns the round-robin pointer to channel 0 at the next word boundary.

---
 rtl/frame_arb_pkg.sv | 15 +
 rtl/frame_slot_arbiter_rr_pick.sv | 35 +++
 rtl/frame_slot_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/frame_arb_pkg.sv
// Shared definitions for the frame slot arbiter: default sizes, the filler
// word sent when no channel has data, and the arbiter state encoding.
package frame_arb_pkg;

    localparam int NCH_DEF    = 4;
    localparam int WORD_W_DEF = 16;

    localparam logic [15:0] FILL_WORD = 16'hA5A5;

    typedef enum logic {
        SELECT = 1'b0,
        SHIFT  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/frame_slot_arbiter_rr_pick.sv
// Combinational round-robin priority picker: returns the first requesting
// channel found when searching base, base+1, ... modulo NCH.
module rr_pick #(
    parameter int NCH  = 4,
    parameter int CH_W = 3
) (
    input  logic [NCH-1:0]  req,
    input  logic [CH_W-1:0] base,
    output logic            found,
    output logic [CH_W-1:0] idx
);

    localparam int NSLOT = 2 ** CH_W;

    // Widen the request vector so any CH_W-bit index selects a defined bit.
    logic [NSLOT-1:0] req_ext;
    logic [CH_W-1:0]  cand;

    assign req_ext = NSLOT'(req);

    // Walk the channels starting at base and keep the first one requesting.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < NCH; i++) begin
            cand = CH_W'((int'(base) + i) % NCH);
            if (!found && req_ext[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/frame_slot_arbiter.sv
// Frame slot arbiter: shares the framer's single-bit data slot between NCH
// word-wide show-ahead FIFOs. Channels are served round-robin one word at a
// time, each word shifted out MSB-first under the framer's i_rack pulses.
// A frm_sync pulse realigns the round-robin pointer to channel 0 at the next
// word boundary; a word in progress is never cut.
// Build option: define FRAME_ARB_FILL_EN to send FILL_WORD (o_grant = NCH)
// whenever all channels are empty, so the framer never stalls.
module frame_slot_arbiter
    import frame_arb_pkg::*;
#(
    parameter int NCH    = NCH_DEF,
    parameter int WORD_W = WORD_W_DEF,
    parameter int CH_W   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NCH-1:0]        ch_emp,
    input  logic [NCH*WORD_W-1:0] ch_dat,
    output logic [NCH-1:0]        ch_rdreq,
    input  logic                  frm_sync,
    output logic                  o_emp,
    output logic                  o_dat,
    input  logic                  i_rack,
    output logic [CH_W-1:0]       o_grant,
    output logic                  o_rack_err
);

    localparam int BC_W  = $clog2(WORD_W);
    localparam int NSLOT = 2 ** CH_W;

    arb_state_e        state_q, state_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [CH_W-1:0]   grant_q, grant_d;
    logic              sync_pend_q, sync_pend_d;
    logic              rack_err_q, rack_err_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [BC_W-1:0]   bitcnt_q, bitcnt_d;

    logic [CH_W-1:0]   base;
    logic [CH_W-1:0]   pick_idx;
    logic              pick_found;
    logic              pop;
    logic [WORD_W-1:0] words [NSLOT];

    // Split the flat head-word bus into an array indexable by channel number.
    always_comb begin
        for (int s = 0; s < NSLOT; s++) begin
            words[s] = '0;
        end
        for (int k = 0; k < NCH; k++) begin
            words[k] = ch_dat[k*WORD_W +: WORD_W];
        end
    end

    // A sync seen now or earlier restarts the search at channel 0.
    assign base = (sync_pend_q || frm_sync) ? '0 : ptr_q;

    rr_pick #(
        .NCH  (NCH),
        .CH_W (CH_W)
    ) u_rr_pick (
        .req   (~ch_emp),
        .base  (base),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Next-state logic: pick and load a word in SELECT, shift it out in SHIFT.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        sync_pend_d = sync_pend_q;
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        pop         = 1'b0;
        rack_err_d  = rack_err_q | (i_rack && (state_q != SHIFT));

        case (state_q)
            SELECT: begin
                if (pick_found) begin
                    pop         = 1'b1;
                    shreg_d     = words[pick_idx];
                    grant_d     = pick_idx;
                    ptr_d       = (pick_idx == CH_W'(NCH - 1)) ? '0 : pick_idx + 1'b1;
                    sync_pend_d = 1'b0;
                    bitcnt_d    = '0;
                    state_d     = SHIFT;
                end else begin
                    // Keep a pending realignment until a real channel is served.
                    sync_pend_d = sync_pend_q | frm_sync;
`ifdef FRAME_ARB_FILL_EN
                    shreg_d  = WORD_W'(FILL_WORD);
                    grant_d  = CH_W'(NCH);
                    bitcnt_d = '0;
                    state_d  = SHIFT;
`endif
                end
            end
            SHIFT: begin
                sync_pend_d = sync_pend_q | frm_sync;
                if (i_rack) begin
                    shreg_d  = {shreg_q[WORD_W-2:0], 1'b0};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == BC_W'(WORD_W - 1)) begin
                        bitcnt_d = '0;
                        state_d  = SELECT;
                    end
                end
            end
            default: state_d = SELECT;
        endcase
    end

    // Pop pulse to the granted channel; suppressed while reset is held.
    always_comb begin
        ch_rdreq = '0;
        for (int k = 0; k < NCH; k++) begin
            ch_rdreq[k] = pop && reset && (pick_idx == CH_W'(k));
        end
    end

    assign o_emp      = (state_q != SHIFT);
    assign o_dat      = (state_q == SHIFT) && shreg_q[WORD_W-1];
    assign o_grant    = grant_q;
    assign o_rack_err = rack_err_q;

    // State register; reset discards any partially sent word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SELECT;
            ptr_q       <= '0;
            grant_q     <= '0;
            sync_pend_q <= 1'b0;
            rack_err_q  <= 1'b0;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            sync_pend_q <= sync_pend_d;
            rack_err_q  <= rack_err_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
        end
    end

endmodule
